// File: rtl/bounded_counter_sched_if.sv
// Request/result bus between requesters and the shared bounded-counter scheduler.
interface bounded_counter_sched_if #(
    parameter int NREQ = 4,
    parameter int W    = 11
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] bound;
    logic [NREQ-1:0]   sel;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic              done;
    logic [IW-1:0]     done_id;
    logic [W-1:0]      m;
    logic [W-1:0]      x;
    logic [W-1:0]      n;

    // Requester side drives requests, bounds and sample selects.
    modport master (
        output req, bound, sel,
        input  gnt, busy, done, done_id, m, x, n
    );

    // Scheduler side.
    modport slave (
        input  req, bound, sel,
        output gnt, busy, done, done_id, m, x, n
    );
endinterface

// File: rtl/bounded_counter_sched.sv
// Round-robin scheduler sharing one bounded sampling counter (x, n, m)
// between NREQ requesters. A granted run counts x from 0 up to the loaded
// bound, optionally sampling x into m, then pulses done for one cycle.
module bounded_counter_sched #(
    parameter int NREQ      = 4,
    parameter int W         = 11,
    parameter int RST_BOUND = 200
) (
    input  logic                  clk,
    input  logic                  rst,
    bounded_counter_sched_if.slave bus
);
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int IW1 = IW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]     gidx_q, gidx_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     done_id_q, done_id_d;
    logic [W-1:0]      x_q, x_d;
    logic [W-1:0]      n_q, n_d;
    logic [W-1:0]      m_q, m_d;

    logic [2*NREQ-1:0] req_rot;
    logic              pick_vld;
    logic [IW-1:0]     pick_idx;
    logic [IW1-1:0]    pick_sum;

    // Rotate requests so bit 0 is the requester at the round-robin pointer.
    assign req_rot = {bus.req, bus.req} >> ptr_q;

    // First set request at or above ptr (wrapping); lowest offset wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        pick_sum = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                pick_vld = 1'b1;
                pick_sum = {1'b0, ptr_q} + IW1'(k);
                if (pick_sum >= IW1'(NREQ))
                    pick_sum = pick_sum - IW1'(NREQ);
                pick_idx = pick_sum[IW-1:0];
            end
        end
    end

    // Next-state and datapath: grant/load in IDLE, count in RUN, release in DONE.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gidx_d    = gidx_q;
        ptr_d     = ptr_q;
        done_id_d = done_id_q;
        x_d       = x_q;
        n_d       = n_q;
        m_d       = m_q;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d         = RUN;
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    gidx_d          = pick_idx;
                    n_d             = bus.bound[pick_idx*W +: W];
                    x_d             = '0;
                    m_d             = '0;
                end
            end
            RUN: begin
                // x stops at n, so it can never wrap even with an all-ones bound.
                if (x_q < n_q) begin
                    x_d = x_q + 1'b1;
                    if (bus.sel[gidx_q])
                        m_d = x_q;
                end else begin
                    state_d   = DONE;
                    done_id_d = gidx_q;
                end
            end
            DONE: begin
                // Finished requester drops to lowest priority for the next pick.
                state_d = IDLE;
                gnt_d   = '0;
                ptr_d   = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gidx_q    <= '0;
            ptr_q     <= '0;
            done_id_q <= '0;
            x_q       <= '0;
            n_q       <= W'(RST_BOUND);
            m_q       <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gidx_q    <= gidx_d;
            ptr_q     <= ptr_d;
            done_id_q <= done_id_d;
            x_q       <= x_d;
            n_q       <= n_d;
            m_q       <= m_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == DONE);
    assign bus.done_id = done_id_q;
    assign bus.x       = x_q;
    assign bus.n       = n_q;
    assign bus.m       = m_q;
endmodule
